// File: rtl/div_16_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_16_seq_pkg : shared constants and types for the fixed-point divider
// | Rev 1.0
// +-----------------------------------------------------------------------------
package div_16_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 15;

  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [15:0] q;
    logic        dz;
    logic        ovf;
  } div_res_t;

endpackage
`default_nettype wire

// File: rtl/div_16_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_16_seq_if : operand/result handshake bundle for div_16_seq
// | Rev 1.0
// +-----------------------------------------------------------------------------
interface div_16_seq_if
  import div_16_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             dz;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dz, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dz, ovf
  );

endinterface
`default_nettype wire

// File: rtl/div_16_seq_udiv_step.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_16_seq_udiv_step : one restoring-division iteration (compare/subtract)
// | Rev 1.0
// +-----------------------------------------------------------------------------
module div_16_seq_udiv_step
  import div_16_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  assign w_trial = {rem, din};
  assign w_diff  = w_trial - {1'b0, divisor};
  assign qbit    = (w_trial >= {1'b0, divisor});

  // The kept remainder is always below the divisor, so it fits in WIDTH bits.
  assign rem_next = qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/div_16_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_16_seq : sequential signed Qm.FRAC divider, q = (a << FRAC) / b, saturating
// | Rev 1.0
// +-----------------------------------------------------------------------------
module div_16_seq
  import div_16_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  div_16_seq_if.slave  bus
);

  localparam int                ITER    = WIDTH + FRAC;
  localparam int                CW      = $clog2(ITER + 1);
  localparam logic [CW-1:0]     LAST    = CW'(ITER);
  localparam logic [WIDTH-1:0]  QMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  QMIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITER-1:0]   POS_LIM = ITER'(QMAX);
  localparam logic [ITER-1:0]   NEG_LIM = ITER'(QMIN);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [ITER-1:0]  r_dq;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_neg;
  logic             r_a_neg;
  logic             r_dz_cap;
  logic [WIDTH-1:0] r_q;
  logic             r_dz;
  logic             r_ovf;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fin;
  logic             w_ovf_fin;

  assign w_a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

  // r_dq starts as the shifted dividend; quotient bits shift in from the LSB.
  div_16_seq_udiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .din      (r_dq[ITER-1]),
    .divisor  (r_div),
    .rem_next (w_rem_next),
    .qbit     (w_qbit)
  );

  always_comb begin
    w_q_fin   = QMAX;
    w_ovf_fin = 1'b0;
    if (r_dz_cap) begin
      w_q_fin = r_a_neg ? QMIN : QMAX;
    end else if (!r_neg) begin
      if (r_dq > POS_LIM) begin
        w_q_fin   = QMAX;
        w_ovf_fin = 1'b1;
      end else begin
        w_q_fin = r_dq[WIDTH-1:0];
      end
    end else begin
      if (r_dq > NEG_LIM) begin
        w_q_fin   = QMIN;
        w_ovf_fin = 1'b1;
      end else begin
        w_q_fin = -r_dq[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dq        <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_neg       <= 1'b0;
      r_a_neg     <= 1'b0;
      r_dz_cap    <= 1'b0;
      r_q         <= '0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_a_neg  <= bus.a[WIDTH-1];
            r_div    <= w_b_mag;
            r_dz_cap <= (bus.b == '0);
            r_dq     <= {w_a_mag, {FRAC{1'b0}}};
            r_rem    <= '0;
            r_cnt    <= '0;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          // ITER shift cycles, then one cycle to register the saturated result.
          if (r_cnt == LAST) begin
            r_q         <= w_q_fin;
            r_dz        <= r_dz_cap;
            r_ovf       <= w_ovf_fin;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_rem <= w_rem_next;
            r_dq  <= {r_dq[ITER-2:0], w_qbit};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
  assign bus.dz        = r_dz;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_div_16_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_div_16_seq : scoreboard bench for div_16_seq at Q1.15 defaults
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tb_div_16_seq;
  import div_16_seq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_16_seq_if #(.WIDTH(16)) bus();

  div_16_seq #(
    .WIDTH (16),
    .FRAC  (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int       n_chk  = 0;
  int       n_pass = 0;
  div_res_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact signed integer division of the scaled dividend.
  function automatic div_res_t model(input logic [15:0] a, input logic [15:0] b);
    div_res_t r;
    longint   sa, sb_v, qq;
    r = '0;
    if (b == 16'h0000) begin
      r.dz = 1'b1;
      r.q  = a[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      qq   = (sa * 32768) / sb_v;
      if (qq > 32767) begin
        r.q = 16'h7FFF; r.ovf = 1'b1;
      end else if (qq < -32768) begin
        r.q = 16'h8000; r.ovf = 1'b1;
      end else begin
        r.q = qq[15:0];
      end
    end
    return r;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit junk);
    div_res_t e;
    logic [17:0] snap;
    int  n;
    bit  seen, busy_ok, stable;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val("in_ready_idle", bus.in_ready, 1);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(a, b));
    if (junk) begin
      bus.a = ~a; bus.b = 16'h0001;
    end else begin
      bus.in_valid = 1'b0;
    end
    n = 0; seen = 0; busy_ok = 1;
    while (n < 100 && !seen) begin
      @(posedge clk); #1; n++;
      if (bus.in_ready) busy_ok = 0;
      if (bus.out_valid) seen = 1;
    end
    bus.in_valid = 1'b0;
    check_val("latency", n, 32);
    check_val("in_ready_busy", {31'd0, busy_ok}, 1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check_val("q", bus.q, e.q);
      check_val("dz", bus.dz, e.dz);
      check_val("ovf", bus.ovf, e.ovf);
    end
    if (hold > 0) begin
      snap = {bus.q, bus.dz, bus.ovf};
      stable = 1;
      repeat (hold) begin
        @(posedge clk); #1;
        if ({bus.q, bus.dz, bus.ovf} !== snap || !bus.out_valid || bus.in_ready) stable = 0;
      end
      check_val("hold_stable", {31'd0, stable}, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val("out_valid_drop", bus.out_valid, 0);
    check_val("in_ready_back", bus.in_ready, 1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          hold;
    bit          junk;
  } vec_t;

  vec_t vecs[$] = '{
    '{16'h2000, 16'h4000, 0, 1'b0},
    '{16'hC000, 16'h4000, 0, 1'b0},
    '{16'h1000, 16'hC000, 0, 1'b1},
    '{16'h4000, 16'h2000, 0, 1'b0},
    '{16'h8000, 16'h0001, 0, 1'b0},
    '{16'h0001, 16'h3000, 0, 1'b0},
    '{16'hFFFF, 16'h3000, 0, 1'b0},
    '{16'h0100, 16'h0000, 0, 1'b0},
    '{16'h8000, 16'h0000, 0, 1'b0},
    '{16'h0000, 16'h0000, 0, 1'b0},
    '{16'h0000, 16'h8000, 0, 1'b0},
    '{16'h8000, 16'h8000, 0, 1'b0},
    '{16'h3000, 16'h7000, 10, 1'b0},
    '{16'hD000, 16'h6000, 0, 1'b0}
  };

  initial begin
    bit ov_seen;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_q", bus.q, 0);
    check_val("rst_dz", bus.dz, 0);
    check_val("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].junk);
    for (int i = 0; i < 6; i++) run_op(16'($urandom), 16'($urandom), 0, 1'b0);

    // Abort mid-calculation.
    bus.a = 16'h2000; bus.b = 16'h4000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", bus.out_valid, 0);
    check_val("abort_in_ready", bus.in_ready, 1);
    check_val("abort_q", bus.q, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen = 1;
    end
    check_val("abort_no_result", {31'd0, ov_seen}, 0);
    check_val("abort_ready_after", bus.in_ready, 1);

    run_op(16'h7FFF, 16'h7FFF, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
